log2_seq_ctrl: RTL and testbench

LOG2_SEQ_CTRL -- requirements
Module: log2_seq_ctrl

---
 rtl/log2_seq_ctrl_if.sv | 24 ++
 rtl/log2_seq_ctrl.sv | 102 ++++++++++
 tb/tb_log2_seq_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/log2_seq_ctrl_if.sv
// Operand/result handshakes plus the shared Log2Table index/data pair.
// The controller is the slave; whoever supplies operands and owns the table is the master.
interface log2_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] In1;
  logic [4:0]  tbl_idx;
  logic [9:0]  tbl_data;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] Out1;
  logic        out_zero;
  logic        busy;

  modport slave (
    input  in_valid, In1, tbl_data, out_ready,
    output in_ready, tbl_idx, out_valid, Out1, out_zero, busy
  );

  modport master (
    output in_valid, In1, tbl_data, out_ready,
    input  in_ready, tbl_idx, out_valid, Out1, out_zero, busy
  );
endinterface

// File: rtl/log2_seq_ctrl.sv
// Sequential log2 of a ufix16 operand: normalise by shifting, look up the fraction in a shared
// registered table, result {exponent, fraction}. Latency 3+s active edges (s = leading zeros); DONE holds until out_ready.
module log2_seq_ctrl (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               enb,
  log2_seq_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NORM = 3'd1,
    LOOK = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q;
  logic [15:0] x_q;
  logic [3:0]  exp_q;
  logic [13:0] out1_q;
  logic        zero_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;

  logic [15:0] x_shl_d;
  logic [3:0]  exp_dec_d;

  assign x_shl_d   = {x_q[14:0], 1'b0};
  assign exp_dec_d = exp_q - 4'd1;

  // A nonzero operand reaches x[15]=1 within 15 shifts, so exp cannot wrap.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q     <= IDLE;
      x_q         <= '0;
      exp_q       <= '0;
      out1_q      <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (enb) begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q        <= bus.In1;
            exp_q      <= 4'd15;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.In1 == 16'd0) begin
              state_q     <= DONE;
              out1_q      <= '0;
              zero_q      <= 1'b1;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= NORM;
            end
          end
        end
        NORM: begin
          if (x_q[15]) begin
            state_q <= LOOK;
          end else begin
            x_q   <= x_shl_d;
            exp_q <= exp_dec_d;
          end
        end
        LOOK: state_q <= WAIT;
        WAIT: begin
          out1_q      <= {exp_q, bus.tbl_data};
          zero_q      <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tbl_idx   = x_q[14:10];
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.Out1      = out1_q;
  assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_log2_seq_ctrl.sv
// Bench for log2_seq_ctrl: directed corner operands, mid-operation reset, then randomised traffic
// with random enb and backpressure, all checked every cycle against a latency/result model.
module tb_log2_seq_ctrl;

  logic i_CLK = 1'b0;
  logic i_RST = 1'b1;
  logic enb   = 1'b0;

  log2_seq_ctrl_if bus ();

  log2_seq_ctrl dut (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .enb   (enb),
    .bus   (bus)
  );

  always #5 i_CLK = ~i_CLK;

  int n_chk  = 0;
  int n_fail = 0;
  bit checking = 1'b1;

  int tbl [32];

  // External Log2Table: registered, gated by the same enb.
  always @(posedge i_CLK) begin
    if (enb) bus.tbl_data <= 10'(tbl[bus.tbl_idx]);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", nm, act, act, req, req, $time);
    end
  endtask

  function automatic int msb(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [4:0] ref_idx(input logic [15:0] v);
    logic [15:0] n;
    n = v << (15 - msb(v));
    return n[14:10];
  endfunction

  function automatic logic [13:0] ref_out(input logic [15:0] v);
    return {4'(msb(v)), 10'(tbl[ref_idx(v)])};
  endfunction

  // Model: phase 0 idle, 1 computing (m_cnt active edges left), 2 result pending.
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic [13:0] m_out   = '0;
  logic [13:0] m_pend  = '0;
  logic        m_zero  = 1'b0;
  logic [4:0]  m_idx   = '0;

  always @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_out   <= '0;
      m_zero  <= 1'b0;
    end else if (enb) begin
      if (m_phase == 0) begin
        if (bus.in_valid) begin
          if (bus.In1 == 16'd0) begin
            m_phase <= 2;
            m_out   <= '0;
            m_zero  <= 1'b1;
          end else begin
            m_phase <= 1;
            m_cnt   <= 3 + 15 - msb(bus.In1);
            m_pend  <= ref_out(bus.In1);
            m_idx   <= ref_idx(bus.In1);
          end
        end
      end else if (m_phase == 1) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_phase <= 2;
          m_out   <= m_pend;
          m_zero  <= 1'b0;
        end
      end else if (bus.out_ready) begin
        m_phase <= 0;
      end
    end
  end

  always @(negedge i_CLK) begin
    #1;
    if (checking) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_phase == 0));
      chk("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
      chk("busy", 32'(bus.busy), 32'(m_phase != 0));
      chk("Out1", 32'(bus.Out1), 32'(m_out));
      chk("out_zero", 32'(bus.out_zero), 32'(m_zero));
      if (m_phase == 1 && m_cnt == 2) chk("tbl_idx_look", 32'(bus.tbl_idx), 32'(m_idx));
    end
  end

  // Directed operation with literal expectations; idx < 0 skips the LOOK index check.
  task automatic do_op(input logic [15:0] v, input logic [13:0] req_out, input logic req_zero,
                       input int req_lat, input int idx);
    int w;
    int lat;
    @(negedge i_CLK);
    enb = 1'b1;
    bus.out_ready = 1'b0;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge i_CLK);
      w++;
    end
    chk("op_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.In1 = v;
    @(posedge i_CLK);
    @(negedge i_CLK);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (idx >= 0 && lat == req_lat - 2) chk("op_tbl_idx", 32'(bus.tbl_idx), 32'(idx));
      @(posedge i_CLK);
      @(negedge i_CLK);
      lat++;
    end
    chk("op_latency", 32'(lat), 32'(req_lat));
    chk("op_Out1", 32'(bus.Out1), 32'(req_out));
    chk("op_out_zero", 32'(bus.out_zero), 32'(req_zero));
    repeat (3) @(negedge i_CLK);
    chk("op_held_Out1", 32'(bus.Out1), 32'(req_out));
    bus.out_ready = 1'b1;
    @(posedge i_CLK);
    @(negedge i_CLK);
    bus.out_ready = 1'b0;
    chk("op_released", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int bp;
    int seen;
    for (int i = 0; i < 32; i++)
      tbl[i] = $rtoi($ln(1.0 + real'(i) / 32.0) / $ln(2.0) * 1024.0 + 0.5);
    bus.in_valid  = 1'b0;
    bus.In1       = '0;
    bus.out_ready = 1'b0;
    bus.tbl_data  = '0;

    repeat (3) @(negedge i_CLK);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_Out1", 32'(bus.Out1), 32'd0);
    i_RST = 1'b0;

    do_op(16'h8000, 14'h3C00, 1'b0, 3, 0);
    do_op(16'h0003, 14'h0657, 1'b0, 17, 16);
    do_op(16'hFFFF, 14'h3FE9, 1'b0, 3, 31);
    do_op(16'h0001, 14'h0000, 1'b0, 18, 0);
    do_op(16'h0000, 14'h0000, 1'b1, 0, -1);

    // Reset in NORM discards the operand.
    @(negedge i_CLK);
    enb = 1'b1;
    bus.in_valid = 1'b1;
    bus.In1 = 16'h0004;
    @(posedge i_CLK);
    @(negedge i_CLK);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge i_CLK);
    chk("mid_busy_before_rst", 32'(bus.busy), 32'd1);
    i_RST = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge i_CLK);
    i_RST = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge i_CLK);
      if (bus.out_valid) seen++;
    end
    chk("mid_rst_no_result", 32'(seen), 32'd0);
    do_op(16'h8000, 14'h3C00, 1'b0, 3, 0);

    // Random traffic with random enb, occasional 10-cycle backpressure and rare resets.
    bp = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge i_CLK);
      i_RST = ($urandom_range(0, 799) == 0);
      enb = ($urandom_range(0, 3) != 0);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.In1 = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
      if (bp > 0) begin
        bus.out_ready = 1'b0;
        bp--;
      end else if (bus.out_valid && $urandom_range(0, 3) == 0) begin
        bus.out_ready = 1'b0;
        bp = 9;
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end

    @(negedge i_CLK);
    i_RST = 1'b0;
    enb = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (30) @(negedge i_CLK);
    chk("drain_idle", 32'(bus.busy), 32'd0);
    checking = 1'b0;
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
